data_memory_lsu: RTL and testbench

DATA_MEMORY_LSU -- requirements
Module: data_memory_lsu

---
 rtl/mem_pkg.sv | 17 +
 rtl/mem_load_align.sv | 27 ++
 rtl/data_memory_lsu.sv | 159 +++++++++++++++
 tb/tb_data_memory_lsu.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the data memory load/store unit.
// Holds the access size encodings, the FSM state type and the error counter width.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int ERR_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } state_t;

endpackage

// File: rtl/mem_load_align.sv
// Combinational load aligner.
// Selects the addressed lanes from an aligned 32-bit word and sign- or zero-extends them.
module mem_load_align
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[8*offset +: 8];
    half_sel = offset[1] ? word[31:16] : word[15:0];
    data     = word;
    case (size)
      SZ_BYTE: data = is_unsigned ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      SZ_HALF: data = is_unsigned ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/data_memory_lsu.sv
// Byte-addressed little-endian data memory behind a three-state request/response handshake.
// Illegal, misaligned or out-of-range accesses are rejected and counted.
module data_memory_lsu
  import mem_pkg::*;
#(
  parameter int DEPTH_BYTES  = 256,
  parameter int ADDR_W       = 32,
  parameter int INIT_PATTERN = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [1:0]           req_size,
  input  logic                 req_unsigned,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [31:0]          req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_rdata,
  output logic                 rsp_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int IDX_W = $clog2(DEPTH_BYTES);

  typedef logic [7:0] mem_t [DEPTH_BYTES];

  function automatic mem_t init_mem();
    mem_t m;
    for (int i = 0; i < DEPTH_BYTES; i++) begin
      m[i] = (INIT_PATTERN != 0) ? 8'(i) : 8'h00;
    end
    return m;
  endfunction

  // Contents are set once at time zero and never touched by reset.
  mem_t mem = init_mem();

  state_t            state;
  logic              lat_we;
  logic [1:0]        lat_size;
  logic              lat_unsigned;
  logic [ADDR_W-1:0] lat_addr;
  logic [31:0]       lat_wdata;

  logic [IDX_W-1:0]  word_base;
  logic [1:0]        offset;
  logic [31:0]       raw_word;
  logic [31:0]       load_data;
  logic [ADDR_W:0]   end_addr;
  logic [3:0]        size_bytes;
  logic              access_err;
  logic [3:0]        byte_en;
  logic [31:0]       lane_data;

  assign offset    = lat_addr[1:0];
  assign word_base = {lat_addr[IDX_W-1:2], 2'b00};
  assign raw_word  = {mem[word_base + IDX_W'(3)], mem[word_base + IDX_W'(2)],
                      mem[word_base + IDX_W'(1)], mem[word_base]};
  assign lane_data = lat_wdata << {offset, 3'b000};

  // The range check uses one extra bit so high addresses cannot wrap into range.
  always_comb begin
    size_bytes = 4'd0;
    byte_en    = 4'b0000;
    access_err = 1'b0;
    case (lat_size)
      SZ_BYTE: begin
        size_bytes = 4'd1;
        byte_en    = 4'b0001 << offset;
      end
      SZ_HALF: begin
        size_bytes = 4'd2;
        byte_en    = offset[1] ? 4'b1100 : 4'b0011;
        access_err = lat_addr[0];
      end
      SZ_WORD: begin
        size_bytes = 4'd4;
        byte_en    = 4'b1111;
        access_err = |lat_addr[1:0];
      end
      default: access_err = 1'b1;
    endcase
    end_addr = {1'b0, lat_addr} + (ADDR_W+1)'(size_bytes);
    if (end_addr > (ADDR_W+1)'(DEPTH_BYTES)) begin
      access_err = 1'b1;
    end
  end

  mem_load_align u_align (
    .word        (raw_word),
    .offset      (offset),
    .size        (lat_size),
    .is_unsigned (lat_unsigned),
    .data        (load_data)
  );

  always_ff @(posedge clk) begin
    if (!rst && state == ST_ACCESS && lat_we && !access_err) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) begin
          mem[word_base + IDX_W'(i)] <= lane_data[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      req_ready    <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= 32'h0;
      rsp_err      <= 1'b0;
      err_cnt      <= '0;
      lat_we       <= 1'b0;
      lat_size     <= SZ_BYTE;
      lat_unsigned <= 1'b0;
      lat_addr     <= '0;
      lat_wdata    <= 32'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            lat_we       <= req_we;
            lat_size     <= req_size;
            lat_unsigned <= req_unsigned;
            lat_addr     <= req_addr;
            lat_wdata    <= req_wdata;
            req_ready    <= 1'b0;
            state        <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          rsp_valid <= 1'b1;
          rsp_err   <= access_err;
          rsp_rdata <= (lat_we || access_err) ? 32'h0 : load_data;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            if (rsp_err && err_cnt != '1) begin
              err_cnt <= err_cnt + 1'b1;
            end
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'h0;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_lsu.sv
// Directed self-checking bench for data_memory_lsu with hand-computed expected values.
// Covers load extension, store lanes, error rejection, backpressure and reset during a store.
module tb_data_memory_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [7:0]  err_cnt;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] rdata;
  logic        err;

  always #5 clk = ~clk;

  data_memory_lsu dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .err_cnt      (err_cnt)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // One full transaction; hold > 0 keeps rsp_ready low that many cycles while
  // a competing request is presented, which must be ignored.
  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input int hold, output logic [31:0] rd, output logic er);
    int n;
    @(negedge clk);
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (req_ready !== 1'b1) checkOutput("ready_timeout", {31'h0, req_ready}, 32'h1);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput("ready_low_access", {31'h0, req_ready}, 32'h0);
    checkOutput("valid_low_access", {31'h0, rsp_valid}, 32'h0);
    @(negedge clk);
    checkOutput("rsp_latency", {31'h0, rsp_valid}, 32'h1);
    rd = rsp_rdata;
    er = rsp_err;
    if (hold > 0) begin
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_size  = 2'b10;
      req_addr  = 32'h0000_0008;
      req_wdata = 32'hDEAD_BEEF;
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        checkOutput("hold_valid", {31'h0, rsp_valid}, 32'h1);
        checkOutput("hold_rdata", rsp_rdata, rd);
        checkOutput("hold_err", {31'h0, rsp_err}, {31'h0, er});
        checkOutput("hold_ready", {31'h0, req_ready}, 32'h0);
      end
      req_valid = 1'b0;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checkOutput("rsp_done", {31'h0, rsp_valid}, 32'h0);
    checkOutput("ready_back", {31'h0, req_ready}, 32'h1);
  endtask

  task automatic loadCheck(input string tag, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] exp_data,
                           input logic exp_err);
    applyStimulus(1'b0, size, uns, addr, 32'h0, 0, rdata, err);
    checkOutput(tag, rdata, exp_data);
    checkOutput({tag, "_err"}, {31'h0, err}, {31'h0, exp_err});
  endtask

  task automatic storeCheck(input string tag, input logic [1:0] size, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic exp_err);
    applyStimulus(1'b1, size, 1'b0, addr, wdata, 0, rdata, err);
    checkOutput(tag, rdata, 32'h0);
    checkOutput({tag, "_err"}, {31'h0, err}, {31'h0, exp_err});
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset_ready", {31'h0, req_ready}, 32'h1);
    checkOutput("reset_valid", {31'h0, rsp_valid}, 32'h0);
    checkOutput("reset_rdata", rsp_rdata, 32'h0);
    checkOutput("reset_err", {31'h0, rsp_err}, 32'h0);
    checkOutput("reset_errcnt", {24'h0, err_cnt}, 32'h0);

    loadCheck("lw_04", 2'b10, 1'b0, 32'h04, 32'h0706_0504, 1'b0);
    loadCheck("lb_80", 2'b00, 1'b0, 32'h80, 32'hFFFF_FF80, 1'b0);
    loadCheck("lhu_82", 2'b01, 1'b1, 32'h82, 32'h0000_8382, 1'b0);
    loadCheck("lh_82", 2'b01, 1'b0, 32'h82, 32'hFFFF_8382, 1'b0);
    loadCheck("lbu_81", 2'b00, 1'b1, 32'h81, 32'h0000_0081, 1'b0);
    loadCheck("lb_7f", 2'b00, 1'b0, 32'h7F, 32'h0000_007F, 1'b0);
    loadCheck("lw_fc", 2'b10, 1'b0, 32'hFC, 32'hFFFE_FDFC, 1'b0);

    storeCheck("sb_05", 2'b00, 32'h05, 32'h1234_56AB, 1'b0);
    loadCheck("lw_04_after_sb", 2'b10, 1'b0, 32'h04, 32'h0706_AB04, 1'b0);
    storeCheck("sh_22", 2'b01, 32'h22, 32'h5555_BEEF, 1'b0);
    loadCheck("lw_20_after_sh", 2'b10, 1'b0, 32'h20, 32'hBEEF_2120, 1'b0);

    loadCheck("lw_06_misalign", 2'b10, 1'b0, 32'h06, 32'h0, 1'b1);
    storeCheck("sh_ff_bad", 2'b01, 32'hFF, 32'hAAAA_AAAA, 1'b1);
    loadCheck("lbu_ff_kept", 2'b00, 1'b1, 32'hFF, 32'h0000_00FF, 1'b0);
    checkOutput("errcnt_two", {24'h0, err_cnt}, 32'h2);

    loadCheck("illegal_size", 2'b11, 1'b0, 32'h00, 32'h0, 1'b1);
    loadCheck("lb_100_range", 2'b00, 1'b0, 32'h100, 32'h0, 1'b1);
    checkOutput("errcnt_four", {24'h0, err_cnt}, 32'h4);

    applyStimulus(1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 3, rdata, err);
    checkOutput("lw_08_held", rdata, 32'h0B0A_0908);
    checkOutput("lw_08_held_err", {31'h0, err}, 32'h0);
    loadCheck("lw_08_not_stored", 2'b10, 1'b0, 32'h08, 32'h0B0A_0908, 1'b0);

    // Reset lands while the store is in ACCESS, so it must not commit.
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = 2'b10;
    req_addr  = 32'h10;
    req_wdata = 32'h1122_3344;
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_mid_valid", {31'h0, rsp_valid}, 32'h0);
    checkOutput("rst_mid_errcnt", {24'h0, err_cnt}, 32'h0);
    checkOutput("rst_mid_ready", {31'h0, req_ready}, 32'h1);
    loadCheck("lw_10_after_rst", 2'b10, 1'b0, 32'h10, 32'h1312_1110, 1'b0);
    checkOutput("errcnt_final", {24'h0, err_cnt}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
